// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: stimulus stage for a master-slave JK flip-flop.
// Commands {op, len} are queued in a small FIFO. Each command is replayed
// onto registered j/k lines for len+1 consecutive clocks. Back-to-back
// commands leave no idle cycle between them.
// Optional feature macro: JK_SEQ_CHECK_EN. When defined, a model of the
// flip-flop's q is kept and any mismatch against q_in sets a sticky err flag.
// When undefined, exp_q/err are tied low and q_in is ignored.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  input  logic             q_in,
  output logic             exp_q,
  output logic             err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 + LEN_W;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Command FIFO storage and bookkeeping
  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [1:0]       head_op;
  logic [LEN_W-1:0] head_len;

  // Sequencer state and its next-state values
  state_t           state;
  state_t           state_n;
  logic [1:0]       op_r;
  logic [1:0]       op_n;
  logic [LEN_W-1:0] rem_r;
  logic [LEN_W-1:0] rem_n;
  logic             j_n;
  logic             k_n;
  logic             done_n;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign head_op   = mem[rd_ptr][ENT_W-1 -: 2];
  assign head_len  = mem[rd_ptr][LEN_W-1:0];
  assign busy      = (state == DRIVE) || !empty;
  assign done      = done_n;

  // Write accepted commands into the slot at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_len};
    end
  end

  // Advance FIFO pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Register the sequencer state, the active command and the j/k drive lines
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_r  <= 2'b00;
      rem_r <= '0;
      j     <= 1'b0;
      k     <= 1'b0;
    end else begin
      state <= state_n;
      op_r  <= op_n;
      rem_r <= rem_n;
      j     <= j_n;
      k     <= k_n;
    end
  end

  // Pick the next command, count down drive cycles and flag the last one
  always_comb begin
    state_n = state;
    op_n    = op_r;
    rem_n   = rem_r;
    j_n     = j;
    k_n     = k;
    pop     = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        j_n = 1'b0;
        k_n = 1'b0;
        if (!empty) begin
          pop     = 1'b1;
          state_n = DRIVE;
          op_n    = head_op;
          rem_n   = head_len;
          j_n     = head_op[1];
          k_n     = head_op[0];
        end
      end
      DRIVE: begin
        if (rem_r != '0) begin
          rem_n = rem_r - LEN_W'(1);
          j_n   = op_r[1];
          k_n   = op_r[0];
        end else begin
          done_n = !rst;
          if (!empty) begin
            pop   = 1'b1;
            op_n  = head_op;
            rem_n = head_len;
            j_n   = head_op[1];
            k_n   = head_op[0];
          end else begin
            state_n = IDLE;
            op_n    = 2'b00;
            rem_n   = '0;
            j_n     = 1'b0;
            k_n     = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        j_n     = 1'b0;
        k_n     = 1'b0;
      end
    endcase
  end

`ifdef JK_SEQ_CHECK_EN
  logic exp_q_r;
  logic err_r;

  // Track the flip-flop's expected q from the j/k it is being driven with; latch any disagreement
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if (q_in != exp_q_r) begin
        err_r <= 1'b1;
      end
      case ({j, k})
        2'b01:   exp_q_r <= 1'b0;
        2'b10:   exp_q_r <= 1'b1;
        2'b11:   exp_q_r <= ~exp_q_r;
        default: exp_q_r <= exp_q_r;
      endcase
    end
  end

  assign exp_q = exp_q_r;
  assign err   = err_r;
`else
  logic unused_q_in;

  assign unused_q_in = q_in;
  assign exp_q       = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer: directed and randomized stimulus for jk_cmd_sequencer,
// checked every cycle against a queue-based reference model of the command
// stream. A behavioural JK flip-flop driven by the DUT's j/k supplies q_in.
// Honours JK_SEQ_CHECK_EN for the exp_q/err expectations.
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int LEN_W = 4;

  typedef struct {
    logic [1:0] op;
    int         len;
  } cmd_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             j;
  logic             k;
  logic             busy;
  logic             done;
  logic             q_in;
  logic             exp_q;
  logic             err;

  logic             ff_q    = 1'b0;
  logic             corrupt = 1'b0;

  // Reference model state
  cmd_t             fifo_m[$];
  int               rem_m;
  logic [1:0]       op_m;
  logic             exp_q_m;
  logic             err_m;
  logic [1:0]       jk_seen;
  logic [1:0]       trace[$];

  int               total;
  int               bad;
  int               done_seen;

  assign q_in = ff_q ^ corrupt;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(
    .DEPTH(DEPTH),
    .LEN_W(LEN_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_len  (cmd_len),
    .j        (j),
    .k        (k),
    .busy     (busy),
    .done     (done),
    .q_in     (q_in),
    .exp_q    (exp_q),
    .err      (err)
  );

  function automatic logic jk_next(logic q, logic [1:0] jk);
    case (jk)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  task automatic check_bit(string tag, logic observed, logic expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic check_int(string tag, int observed, int expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance the model across one rising edge using the inputs held during the previous cycle
  task automatic model_edge();
    logic [1:0] jk_pre;
    logic       qin_pre;
    logic       acc;
    cmd_t       c;
    jk_pre  = (rem_m > 0) ? op_m : 2'b00;
    qin_pre = ff_q ^ corrupt;
    acc     = cmd_valid && !rst && (fifo_m.size() < DEPTH);
    if (rst) begin
      fifo_m.delete();
      rem_m   = 0;
      op_m    = 2'b00;
      exp_q_m = 1'b0;
      err_m   = 1'b0;
      ff_q    = 1'b0;
    end else begin
      if (qin_pre !== exp_q_m) err_m = 1'b1;
      exp_q_m = jk_next(exp_q_m, jk_pre);
      ff_q    = jk_next(ff_q, jk_seen);
      if (rem_m > 0) rem_m--;
      if (rem_m == 0 && fifo_m.size() > 0) begin
        c     = fifo_m.pop_front();
        op_m  = c.op;
        rem_m = c.len + 1;
      end
      if (acc) begin
        c.op  = cmd_op;
        c.len = int'(cmd_len);
        fifo_m.push_back(c);
      end
    end
  endtask

  task automatic check_output();
    logic [1:0] exp_jk;
    logic       eq_exp;
    logic       err_exp;
    exp_jk = (rem_m > 0) ? op_m : 2'b00;
`ifdef JK_SEQ_CHECK_EN
    eq_exp  = exp_q_m;
    err_exp = err_m;
`else
    eq_exp  = 1'b0;
    err_exp = 1'b0;
`endif
    jk_seen = {j, k};
    trace.push_back({j, k});
    if (done === 1'b1) done_seen++;
    check_bit("j", j, exp_jk[1]);
    check_bit("k", k, exp_jk[0]);
    check_bit("done", done, rem_m == 1);
    check_bit("busy", busy, (rem_m > 0) || (fifo_m.size() > 0));
    check_bit("cmd_ready", cmd_ready, !rst && (fifo_m.size() < DEPTH));
    check_bit("exp_q", exp_q, eq_exp);
    check_bit("err", err, err_exp);
  endtask

  task automatic apply_stimulus(logic v, logic [1:0] op, int len, logic r, logic c);
    cmd_valid = v;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    rst       = r;
    corrupt   = c;
    @(posedge clk);
    #1;
    model_edge();
    check_output();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 2'b00, 0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && busy === 1'b1; i++) apply_stimulus(1'b0, 2'b00, 0, 1'b0, 1'b0);
    check_bit("drain_timeout_busy", busy, 1'b0);
  endtask

  initial begin
    logic [1:0] s2_exp [6];
    total     = 0;
    bad       = 0;
    done_seen = 0;
    rem_m     = 0;
    op_m      = 2'b00;
    exp_q_m   = 1'b0;
    err_m     = 1'b0;
    jk_seen   = 2'b00;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = '0;
    rst       = 1'b1;
    s2_exp    = '{2'b10, 2'b00, 2'b11, 2'b11, 2'b11, 2'b00};

    $display("[TB] reset");
    apply_stimulus(1'b0, 2'b00, 0, 1'b1, 1'b0);
    apply_stimulus(1'b1, 2'b10, 3, 1'b1, 1'b0);

    $display("[TB] single reset command, len 1");
    done_seen = 0;
    apply_stimulus(1'b1, 2'b01, 1, 1'b0, 1'b0);
    idle(6);
    check_int("s1_done_count", done_seen, 1);

    $display("[TB] back-to-back set/hold/toggle");
    done_seen = 0;
    apply_stimulus(1'b1, 2'b10, 0, 1'b0, 1'b0);
    trace.delete();
    apply_stimulus(1'b1, 2'b00, 0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 2'b11, 2, 1'b0, 1'b0);
    idle(8);
    for (int i = 0; i < 6; i++) check_int($sformatf("s2_jk_trace_%0d", i), int'(trace[i]), int'(s2_exp[i]));
    check_int("s2_done_count", done_seen, 3);

    $display("[TB] fill FIFO with long commands");
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 2'($urandom_range(0, 3)), 15, 1'b0, 1'b0);
    drain();

    $display("[TB] reset in the middle of a long toggle");
    done_seen = 0;
    apply_stimulus(1'b1, 2'b11, 10, 1'b0, 1'b0);
    apply_stimulus(1'b1, 2'b10, 3, 1'b0, 1'b0);
    apply_stimulus(1'b1, 2'b01, 2, 1'b0, 1'b0);
    idle(3);
    apply_stimulus(1'b1, 2'b10, 0, 1'b1, 1'b0);
    check_bit("s4_j_after_rst", j, 1'b0);
    check_bit("s4_busy_after_rst", busy, 1'b0);
    idle(14);
    check_int("s4_done_count", done_seen, 0);

    $display("[TB] q checking with one corrupted cycle");
    apply_stimulus(1'b1, 2'b10, 1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 2'b11, 2, 1'b0, 1'b0);
    apply_stimulus(1'b1, 2'b01, 1, 1'b0, 1'b0);
    idle(4);
    apply_stimulus(1'b0, 2'b00, 0, 1'b0, 1'b1);
    idle(6);
    apply_stimulus(1'b0, 2'b00, 0, 1'b1, 1'b0);
    idle(2);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 500; i++) begin
      apply_stimulus($urandom_range(0, 99) < 55,
                     2'($urandom_range(0, 3)),
                     ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3)),
                     $urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < 2);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
